// File: rtl/seg_scan_n_if.sv
// Bus between the score/timer logic and the seg_scan_n display driver.
// The master side writes display data; the slave side (the driver) returns the pin-level signals.
interface seg_scan_n_if #(
    parameter int DIGITS = 4
);
    // load is a single-cycle strobe with no back-pressure: whenever load is high on a
    // clock edge, digits_in/dp_in/blank_in/bright are captured that same edge.
    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic [3:0]            bright;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output load, digits_in, dp_in, blank_in, bright,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  load, digits_in, dp_in, blank_in, bright,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg_scan_n.sv
// Multiplexed common-anode 7-segment scan driver for DIGITS digits with a double-buffered display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_n #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    seg_scan_n_if.slave  bus
);
    localparam int SLOT16 = REFRESH_DIV / 16;
    localparam int PCW    = $clog2(REFRESH_DIV);
    localparam int MW     = $clog2(SLOT16) + 1;
    localparam int PW     = 4 + MW;
    localparam int SW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PCW-1:0]        pc_q, pc_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic                  pending_q, pending_d;

    logic [4*DIGITS-1:0]   digits_sh_q, digits_sh_d;
    logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]     blank_sh_q, blank_sh_d;
    logic [3:0]            bright_sh_q, bright_sh_d;

    logic [4*DIGITS-1:0]   digits_act_q, digits_act_d;
    logic [DIGITS-1:0]     dp_act_q, dp_act_d;
    logic [DIGITS-1:0]     blank_act_q, blank_act_d;
    logic [3:0]            bright_act_q, bright_act_d;

    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_term;
    logic                  wrap;
    logic [PW-1:0]         thresh;
    logic                  on_time;
    logic [3:0]            nibble;
    logic                  dig_blank;
    logic [DIGITS-1:0]     lz_mask;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    assign slot_term = (pc_q == PCW'(REFRESH_DIV - 1));
    assign wrap      = slot_term && (sel_q == SW'(DIGITS - 1));

`ifdef SEG_SCAN_LZB_EN
    // Suppress zeros from the most significant digit down; digit 0 always stays visible.
    logic lz_run;
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (digits_act_q[4*i +: 4] == 4'h0) && !dp_act_q[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        pc_d  = slot_term ? '0 : pc_q + PCW'(1);
        sel_d = sel_q;
        if (slot_term) begin
            sel_d = wrap ? '0 : sel_q + SW'(1);
        end
    end

    // Shadow captures every load; active only changes at the frame wrap so a frame is never torn.
    always_comb begin
        digits_sh_d  = digits_sh_q;
        dp_sh_d      = dp_sh_q;
        blank_sh_d   = blank_sh_q;
        bright_sh_d  = bright_sh_q;
        digits_act_d = digits_act_q;
        dp_act_d     = dp_act_q;
        blank_act_d  = blank_act_q;
        bright_act_d = bright_act_q;
        pending_d    = pending_q;
        if (bus.load) begin
            digits_sh_d = bus.digits_in;
            dp_sh_d     = bus.dp_in;
            blank_sh_d  = bus.blank_in;
            bright_sh_d = bus.bright;
            pending_d   = 1'b1;
        end
        if (wrap) begin
            if (bus.load) begin
                digits_act_d = bus.digits_in;
                dp_act_d     = bus.dp_in;
                blank_act_d  = bus.blank_in;
                bright_act_d = bus.bright;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                digits_act_d = digits_sh_q;
                dp_act_d     = dp_sh_q;
                blank_act_d  = blank_sh_q;
                bright_act_d = bright_sh_q;
                pending_d    = 1'b0;
            end
        end
    end

    // (bright+1)*SLOT16 written as bright*SLOT16+SLOT16 so the 4-bit operand never overflows.
    assign thresh    = PW'(bright_act_q) * PW'(SLOT16) + PW'(SLOT16);
    assign on_time   = ({1'b0, pc_q} < thresh);
    assign nibble    = digits_act_q[{sel_q, 2'b00} +: 4];
    assign dig_blank = blank_act_q[sel_q] | lz_mask[sel_q];

    always_comb begin
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = wrap;
        if (!dig_blank) begin
            seg_d = decode(nibble);
            dp_d  = ~dp_act_q[sel_q];
            if (on_time) begin
                an_d = ~(DIGITS'(1) << sel_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= '0;
            sel_q        <= '0;
            pending_q    <= 1'b0;
            digits_sh_q  <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '1;
            bright_sh_q  <= 4'hF;
            digits_act_q <= '0;
            dp_act_q     <= '0;
            blank_act_q  <= '1;
            bright_act_q <= 4'hF;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            sel_q        <= sel_d;
            pending_q    <= pending_d;
            digits_sh_q  <= digits_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            bright_sh_q  <= bright_sh_d;
            digits_act_q <= digits_act_d;
            dp_act_q     <= dp_act_d;
            blank_act_q  <= blank_act_d;
            bright_act_q <= bright_act_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_n.sv
// Scoreboard bench for seg_scan_n: a frame-level model predicts every output cycle into exp_q.
// Honours SEG_SCAN_LZB_EN the same way the design does, so either build can be checked.
module tb_seg_scan_n;
    localparam int D     = 4;
    localparam int RD    = 16;
    localparam int FRAME = D * RD;
    localparam int W     = D + 7 + 1 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_n_if #(.DIGITS(D)) bus ();

    seg_scan_n #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model: time since reset in cycles, plus shadow and active display buffers.
    int         cyc = 0;
    bit         pending = 0;
    logic [15:0] sh_dig, act_dig;
    logic [D-1:0] sh_dp, act_dp, sh_blank, act_blank;
    logic [3:0]  sh_bright, act_bright;

    function automatic logic [D-1:0] lzb_mask(input logic [15:0] dig, input logic [D-1:0] dpv);
        logic [D-1:0] m;
        m = '0;
`ifdef SEG_SCAN_LZB_EN
        for (int i = D - 1; i >= 1; i--) begin
            if (dig[4*i +: 4] != 4'h0 || dpv[i]) break;
            m[i] = 1'b1;
        end
`endif
        return m;
    endfunction

    function automatic logic [W-1:0] predict(input int pc, input int sel, input bit fd);
        logic [D-1:0] an_e;
        logic [6:0]   seg_e;
        logic         dp_e;
        logic [D-1:0] lz;
        bit           blanked;
        lz      = lzb_mask(act_dig, act_dp);
        blanked = act_blank[sel] || lz[sel];
        an_e    = '1;
        seg_e   = 7'h7F;
        dp_e    = 1'b1;
        if (!blanked) begin
            seg_e = dec_tab[act_dig[4*sel +: 4]];
            dp_e  = ~act_dp[sel];
            if (pc < (int'(act_bright) + 1) * (RD / 16)) an_e[sel] = 1'b0;
        end
        return {an_e, seg_e, dp_e, fd};
    endfunction

    always @(posedge clk) begin
        int pc;
        int sel;
        bit wrap;
        if (!rst_n) begin
            exp_q.push_back({{D{1'b1}}, 7'h7F, 1'b1, 1'b0});
            cyc        = 0;
            pending    = 0;
            act_dig    = '0;
            act_dp     = '0;
            act_blank  = '1;
            act_bright = 4'hF;
        end else begin
            pc   = cyc % RD;
            sel  = (cyc / RD) % D;
            wrap = (pc == RD - 1) && (sel == D - 1);
            exp_q.push_back(predict(pc, sel, wrap));
            if (bus.load) begin
                sh_dig    = bus.digits_in;
                sh_dp     = bus.dp_in;
                sh_blank  = bus.blank_in;
                sh_bright = bus.bright;
                pending   = 1;
            end
            if (wrap && pending) begin
                act_dig    = sh_dig;
                act_dp     = sh_dp;
                act_blank  = sh_blank;
                act_bright = sh_bright;
                pending    = 0;
            end
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",         32'(bus.an),         32'(e[W-1 -: D]));
            check("seg",        32'(bus.seg),        32'(e[8:2]));
            check("dp",         32'(bus.dp),         32'(e[1]));
            check("frame_done", 32'(bus.frame_done), 32'(e[0]));
        end
    end

    task automatic drive_load(input logic [15:0] dig, input logic [D-1:0] dpv,
                              input logic [D-1:0] blk, input logic [3:0] br);
        bus.digits_in = dig;
        bus.dp_in     = dpv;
        bus.blank_in  = blk;
        bus.bright    = br;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] dig, input logic [D-1:0] dpv,
                           input logic [D-1:0] blk, input logic [3:0] br);
        @(negedge clk);
        drive_load(dig, dpv, blk, br);
    endtask

    // Advance to the negedge whose following posedge has frame position fpos.
    task automatic goto_pos(input int fpos);
        int n;
        n = 0;
        @(negedge clk);
        while ((cyc % FRAME) != fpos && n < FRAME + 2) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((cyc % FRAME) != fpos) begin
            failures++;
            $display("FAIL goto_pos got=%0d exp=%0d", cyc % FRAME, fpos);
        end
    endtask

    initial begin
        logic [15:0] rd;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.blank_in  = '0;
        bus.bright    = 4'hF;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);

        do_load(16'h12AF, 4'b0000, 4'b0000, 4'd15);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h12AF, 4'b0100, 4'b0000, 4'd3);
        repeat (2 * FRAME) @(negedge clk);

        goto_pos(3);
        drive_load(16'h1111, 4'b0000, 4'b0000, 4'd15);
        repeat (5) @(negedge clk);
        drive_load(16'h2222, 4'b0000, 4'b0000, 4'd15);
        repeat (2 * FRAME) @(negedge clk);

        goto_pos(FRAME - 1);
        drive_load(16'h3C4E, 4'b1001, 4'b0010, 4'd7);
        repeat (FRAME) @(negedge clk);

        goto_pos(2 * RD + 5);
        drive_load(16'h9876, 4'b0000, 4'b0000, 4'd15);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        do_load(16'h0050, 4'b0000, 4'b0000, 4'd15);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0000, 4'b0000, 4'b0000, 4'd15);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0005, 4'b0100, 4'b0000, 4'd8);
        repeat (2 * FRAME) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < D; j++) begin
                rd[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            do_load(rd, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                    4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 2 * FRAME)) @(negedge clk);
        end

        repeat (FRAME + 2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_n.md
# seg_scan_n

Parametrised multiplexed 7-segment scan driver for N common-anode digits, successor to the fixed 4-digit driver. It runs off the system clock with an internal slot prescaler and double-buffers the display data so a frame never shows a torn value. It also adds per-digit blanking, per-digit decimal points and duty-cycle brightness control. It sits between the score/timer logic and the board's seg/an/dp pins.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clock cycles per digit slot; must be a multiple of 16, ≥16
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- load  in  1  one-cycle strobe: capture digits_in/dp_in/blank_in/bright into shadow buffer
- digits_in  in  4*DIGITS  hex nibble per digit, digit i = [4i+3:4i], digit 0 rightmost
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit i dark
- bright  in  4  on-time per slot in sixteenths minus one (15 = full)
- seg  out  7  segments active-low, bit6=a … bit0=g
- dp  out  1  decimal point, active-low
- an  out  DIGITS  anodes active-low, one-hot-low or all high
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Prescaler pc counts 0..REFRESH_DIV-1; at pc terminal, select advances mod DIGITS. Terminal with select=DIGITS-1 is the frame boundary (wrap).
- load copies inputs into shadow and sets pending. Load while pending overwrites shadow (last wins).
- At wrap, if pending: shadow → active, pending cleared. Load in the same cycle as wrap: the new inputs go straight to active, pending cleared.
- Anode for digit sel asserted while pc < (bright_act+1)*(REFRESH_DIV/16) and digit not blanked; otherwise an all high.
- Decode: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- Blanked digit: an bit high, seg 1111111, dp 1.
- Multiplier width: 4b × clog2(REFRESH_DIV/16)+1 b, unsigned, no truncation.

## Timing
- Reset values: an all 1, seg 1111111, dp 1, frame_done 0, pc 0, select 0, pending 0, active blank all 1, active bright 15, active digits/dp 0. Display is dark until first load is committed.
- Outputs registered: an/seg/dp reflect (pc, select) of the previous cycle, i.e. one-cycle latency.
- frame_done asserted in the cycle after wrap, for exactly one cycle.
- Load-to-visible latency: ≤ DIGITS*REFRESH_DIV+1 cycles. No partial-frame update is permitted.
- rst_n low mid-frame: all state returns to reset values on the next edge. A pending load is discarded.
- DIGITS=1: every slot terminal is a wrap.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking. Starting from digit DIGITS-1 downward, digits whose active nibble is 0 and whose dp is clear are blanked, until the first nonzero or dp digit. Digit 0 is never suppressed. Evaluated on active buffer. Explicit blank_in still applies.
- Undefined: only blank_in blanks digits; zeros display as "0".

## Test plan
- DIGITS=4, REFRESH_DIV=16, no load after reset → an=1111, seg=1111111 for 200 cycles; frame_done pulses every 64 cycles.
- load digits_in=16'h12AF, blank=0, bright=15 → after next wrap, slots show an=1110 seg=0111000, 1101 0001000, 1011 0010010, 0111 1001111, each 16 cycles.
- bright=3 → each anode low for exactly 4 of 16 cycles per slot, high for the remaining 12.
- load 16'h1111 then 16'h2222 in the same frame → only 2222 appears at wrap. Load coincident with wrap → visible in the very next slot.
- rst_n low for one cycle mid-slot 2 with pending load → outputs dark next cycle, pending dropped.
- SEG_SCAN_LZB_EN, value 16'h0050, dp_in=0 → digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. Value 16'h0000 → only digit 0 lit.
